// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM encoding and index-width helper for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder, first set request at or after ptr_i wrapping to 0
module rr_pick #(
  parameter int N = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);
  logic found;
  logic [IDX_W-1:0] k;
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    found = 1'b0;
    k = '0;
    for (int o = 0; o < N; o++) begin
      k = IDX_W'((int'(ptr_i) + o) % N);
      if (!found && req_i[k]) begin
        found = 1'b1;
        grant_o[k] = 1'b1;
        idx_o = k;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port among NUM_REQ producers.
// Define ARB_BURST_EN to let a winner keep the port for up to MAX_BURST consecutive writes.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 4,
  localparam int IDX_W = idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          fifo_wr_en_o,
  input  logic                          fifo_full_i,
  output logic [IDX_W-1:0]              owner_o
);
  arb_state_e state_q;
  logic [IDX_W-1:0] rr_q, rr_d, owner_q, owner_d, pick_idx, win_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic held, xfer;

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] k);
    return (k == IDX_W'(NUM_REQ - 1)) ? '0 : k + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i  (req_valid_i),
    .ptr_i  (rr_q),
    .grant_o(pick_grant),
    .idx_o  (pick_idx)
  );

  // A locked owner keeps the port only while it still presents a word; grants vanish during reset
  always_comb begin
    held = (state_q == ST_LOCK) && req_valid_i[owner_q];
    win_idx = held ? owner_q : pick_idx;
    grant_o = !reset_n ? '0 : held ? NUM_REQ'(1) << owner_q : pick_grant;
    xfer = |grant_o && !fifo_full_i;
    req_ready_o = grant_o & {NUM_REQ{~fifo_full_i}};
    fifo_wr_en_o = xfer;
    fifo_data_o = '0;
    for (int i = 0; i < NUM_REQ; i++)
      fifo_data_o = fifo_data_o | ({DATA_WIDTH{grant_o[i]}} & req_data_i[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rr_q <= '0;
      owner_q <= '0;
    end else begin
      rr_q <= rr_d;
      owner_q <= owner_d;
    end

  assign owner_o = owner_q;

`ifdef ARB_BURST_EN
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  arb_state_e state_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end

  // A full FIFO freezes everything, including a lock in progress
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    rr_d = rr_q;
    owner_d = owner_q;
    if (!fifo_full_i) begin
      if (held) begin
        burst_d = burst_q + 1'b1;
        if (burst_d == BURST_W'(MAX_BURST)) begin
          state_d = ST_IDLE;
          burst_d = '0;
          rr_d = nxt(owner_q);
        end
      end else if (state_q == ST_LOCK) begin
        state_d = ST_IDLE;
        burst_d = '0;
        rr_d = xfer ? nxt(win_idx) : nxt(owner_q);
        owner_d = xfer ? win_idx : owner_q;
      end else if (xfer) begin
        owner_d = win_idx;
        if (MAX_BURST > 1) begin
          state_d = ST_LOCK;
          burst_d = BURST_W'(1);
        end else begin
          rr_d = nxt(win_idx);
        end
      end
    end
  end
`else
  assign state_q = ST_IDLE;

  always_comb begin
    rr_d = xfer ? nxt(win_idx) : rr_q;
    owner_d = xfer ? win_idx : owner_q;
  end
`endif
endmodule
